// File: rtl/conv_pkg.sv
// Shared FSM state type, default layer geometry and width helper for conv_layer_sched.
// Optional ReLU clamp on captured words is enabled by defining CONV_RELU_EN.
package conv_pkg;

  typedef enum logic [2:0] {IDLE, ENG_RST, RUN, CAPTURE, DONE} state_t;

  // Geometry of the default layer; modules recompute these from their own parameters.
  localparam int OUT_SZ  = (32 - 5 + 1) * (32 - 5 + 1) * 16;
  localparam int FILT_SZ = 1 * 5 * 5 * 16;
  localparam int NPASS   = (6 + 2 - 1) / 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/conv_layer_sched_engine.sv
// Single-filter convolution engine: after its reset releases it produces one output word per
// clock (row-major, word 0 at MSB) and then holds the full result until reset again.
module convLayerSingle
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 1,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [D*H*W*DATA_WIDTH-1:0]             image,
  input  logic [D*F*F*DATA_WIDTH-1:0]             filter,
  output logic [(H-F+1)*(W-F+1)*DATA_WIDTH-1:0]   outputConv
);

  localparam int OH   = H - F + 1;
  localparam int OW   = W - F + 1;
  localparam int NW   = OH * OW;
  localparam int FRAC = DATA_WIDTH / 2;
  localparam int ACCW = 2 * DATA_WIDTH + 8;
  localparam int RW   = clog2(H + 1);
  localparam int CLW  = clog2(W + 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(OH - 1);
  localparam logic [CLW-1:0] COL_LAST = CLW'(OW - 1);

  logic [RW-1:0]              row_reg;
  logic [CLW-1:0]             col_reg;
  logic                       fin_reg;
  logic [NW*DATA_WIDTH-1:0]   out_reg;
  logic signed [ACCW-1:0]     acc;
  logic signed [DATA_WIDTH-1:0] pix;
  logic signed [DATA_WIDTH-1:0] coef;
  logic signed [2*DATA_WIDTH-1:0] prod;
  int                         img_idx;
  int                         flt_idx;
  int                         out_idx;

  // Multiply-accumulate of the F x F x D window anchored at (row_reg, col_reg).
  always_comb begin
    acc     = '0;
    pix     = '0;
    coef    = '0;
    prod    = '0;
    img_idx = 0;
    flt_idx = 0;
    for (int d = 0; d < D; d++) begin
      for (int i = 0; i < F; i++) begin
        for (int j = 0; j < F; j++) begin
          img_idx = (d * H + int'(row_reg) + i) * W + int'(col_reg) + j;
          flt_idx = (d * F + i) * F + j;
          pix     = image[(D*H*W-1-img_idx)*DATA_WIDTH +: DATA_WIDTH];
          coef    = filter[(D*F*F-1-flt_idx)*DATA_WIDTH +: DATA_WIDTH];
          prod    = pix * coef;
          acc     = acc + ACCW'(prod);
        end
      end
    end
  end

  assign out_idx = int'(row_reg) * OW + int'(col_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      row_reg <= '0;
      col_reg <= '0;
      fin_reg <= 1'b0;
      out_reg <= '0;
    end else if (!fin_reg) begin
      out_reg[(NW-1-out_idx)*DATA_WIDTH +: DATA_WIDTH] <= DATA_WIDTH'(acc >>> FRAC);
      if (col_reg == COL_LAST) begin
        col_reg <= '0;
        if (row_reg == ROW_LAST) fin_reg <= 1'b1;
        else                     row_reg <= row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  assign outputConv = out_reg;

endmodule

// File: rtl/conv_layer_sched.sv
// Multi-filter conv layer controller: runs K filters through P engines in ceil(K/P) passes.
// Define CONV_RELU_EN to clamp negative captured words to zero.
module conv_layer_sched
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 1,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5,
  parameter int K          = 6,
  parameter int P          = 2,
  parameter int ENGINE_LAT = 4369
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [D*H*W*DATA_WIDTH-1:0]               image,
  input  logic [K*D*F*F*DATA_WIDTH-1:0]             filters,
  output logic                                      busy,
  output logic                                      done,
  output logic [K*(H-F+1)*(W-F+1)*DATA_WIDTH-1:0]   outputConv
);

  localparam int OUT_SZ  = (H - F + 1) * (W - F + 1) * DATA_WIDTH;
  localparam int FILT_SZ = D * F * F * DATA_WIDTH;
  localparam int NPASS   = (K + P - 1) / P;
  localparam int CW      = clog2(ENGINE_LAT + 1);
  localparam int PW      = clog2(NPASS + 1);
  localparam logic [CW-1:0] LAT_LAST  = CW'(ENGINE_LAT - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(NPASS - 1);

  state_t                       state_reg, state_next;
  logic [PW-1:0]                pass_reg, pass_next;
  logic [CW-1:0]                cnt_reg, cnt_next;
  logic                         eng_rst;
  logic                         capture;
  logic                         load;
  logic [D*H*W*DATA_WIDTH-1:0]  image_reg;
  logic [K*FILT_SZ-1:0]         filt_reg;
  logic [NPASS*P*FILT_SZ-1:0]   filt_pad;
  logic [FILT_SZ-1:0]           eng_filt [P];
  logic [OUT_SZ-1:0]            eng_out  [P];
  logic [OUT_SZ-1:0]            cap_data [P];
  logic [OUT_SZ-1:0]            out_reg  [K];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      pass_reg  <= '0;
      cnt_reg   <= '0;
      image_reg <= '0;
      filt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pass_reg  <= pass_next;
      cnt_reg   <= cnt_next;
      if (load) begin
        image_reg <= image;
        filt_reg  <= filters;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    pass_next  = pass_reg;
    cnt_next   = cnt_reg;
    busy       = 1'b0;
    done       = 1'b0;
    eng_rst    = 1'b1;
    capture    = 1'b0;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ENG_RST;
          pass_next  = '0;
          load       = 1'b1;
        end
      end
      ENG_RST: begin
        busy       = 1'b1;
        cnt_next   = '0;
        state_next = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        eng_rst  = 1'b0;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAT_LAST) state_next = CAPTURE;
      end
      CAPTURE: begin
        busy    = 1'b1;
        eng_rst = 1'b0;
        capture = 1'b1;
        if (pass_reg == PASS_LAST) begin
          state_next = DONE;
        end else begin
          pass_next  = pass_reg + 1'b1;
          state_next = ENG_RST;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Zero-padded filter bank: engines past the last filter in a short pass see an all-zero kernel.
  always_comb begin
    filt_pad              = '0;
    filt_pad[K*FILT_SZ-1:0] = filt_reg;
  end

  generate
    for (genvar gi = 0; gi < P; gi++) begin : g_eng
      assign eng_filt[gi] = filt_pad[(int'(pass_reg)*P + gi)*FILT_SZ +: FILT_SZ];
      convLayerSingle #(
        .DATA_WIDTH(DATA_WIDTH), .D(D), .H(H), .W(W), .F(F)
      ) u_eng (
        .clk(clk),
        .reset(eng_rst),
        .image(image_reg),
        .filter(eng_filt[gi]),
        .outputConv(eng_out[gi])
      );
    end
  endgenerate

  always_comb begin
    for (int e = 0; e < P; e++) begin
      cap_data[e] = eng_out[e];
`ifdef CONV_RELU_EN
      for (int w = 0; w < OUT_SZ / DATA_WIDTH; w++) begin
        if (eng_out[e][w*DATA_WIDTH + DATA_WIDTH - 1]) cap_data[e][w*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
`endif
    end
  end

  // Filter k is owned by engine k%P during pass k/P; other slices hold their value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < K; k++) out_reg[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < K; k++) begin
        if (pass_reg == PW'(k / P)) out_reg[k] <= cap_data[k % P];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_out
      assign outputConv[gi*OUT_SZ +: OUT_SZ] = out_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_conv_layer_sched.sv
// Randomized self-checking bench: three schedulers (P=2, P=1, P=3) on the same stimulus,
// compared against a direct convolution model.
module tb_conv_layer_sched;

  localparam int DW = 16, D = 1, H = 4, W = 4, F = 3, K = 3, LAT = 49;
  localparam int OH = H - F + 1, OW = W - F + 1, NOW = OH * OW;
  localparam int OUT_SZ = NOW * DW, FILT_SZ = D * F * F * DW;
  localparam int IMG_BITS = D * H * W * DW, FLT_BITS = K * FILT_SZ, OC_BITS = K * OUT_SZ;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [IMG_BITS-1:0]  image;
  logic [FLT_BITS-1:0]  filters;
  logic [2:0]           busy_v;
  logic [2:0]           done_v;
  logic [OC_BITS-1:0]   oc [3];
  int                   errors = 0;
  int                   checks = 0;
  int                   pvals [3] = '{2, 1, 3};

  always #5 clk = ~clk;

  conv_layer_sched #(.DATA_WIDTH(DW), .D(D), .H(H), .W(W), .F(F), .K(K), .P(2), .ENGINE_LAT(LAT))
    u_p2 (.clk(clk), .reset(reset), .start(start), .image(image), .filters(filters),
          .busy(busy_v[0]), .done(done_v[0]), .outputConv(oc[0]));
  conv_layer_sched #(.DATA_WIDTH(DW), .D(D), .H(H), .W(W), .F(F), .K(K), .P(1), .ENGINE_LAT(LAT))
    u_p1 (.clk(clk), .reset(reset), .start(start), .image(image), .filters(filters),
          .busy(busy_v[1]), .done(done_v[1]), .outputConv(oc[1]));
  conv_layer_sched #(.DATA_WIDTH(DW), .D(D), .H(H), .W(W), .F(F), .K(K), .P(3), .ENGINE_LAT(LAT))
    u_p3 (.clk(clk), .reset(reset), .start(start), .image(image), .filters(filters),
          .busy(busy_v[2]), .done(done_v[2]), .outputConv(oc[2]));

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Direct convolution: Q8 product sum, arithmetic shift by 8, wrap to DW bits.
  function automatic logic [OC_BITS-1:0] model(input logic [IMG_BITS-1:0] img,
                                               input logic [FLT_BITS-1:0] flt);
    logic [OC_BITS-1:0]    res;
    logic signed [DW-1:0]  px, cf;
    logic [DW-1:0]         wv;
    longint                s;
    res = '0;
    for (int k = 0; k < K; k++)
      for (int r = 0; r < OH; r++)
        for (int c = 0; c < OW; c++) begin
          s = 0;
          for (int d = 0; d < D; d++)
            for (int i = 0; i < F; i++)
              for (int j = 0; j < F; j++) begin
                px = img[(D*H*W-1-((d*H+r+i)*W+c+j))*DW +: DW];
                cf = flt[k*FILT_SZ + (D*F*F-1-((d*F+i)*F+j))*DW +: DW];
                s  = s + longint'(px) * longint'(cf);
              end
          wv = DW'(s >>> 8);
`ifdef CONV_RELU_EN
          if (wv[DW-1]) wv = '0;
`endif
          res[k*OUT_SZ + (NOW-1-(r*OW+c))*DW +: DW] = wv;
        end
    return res;
  endfunction

  function automatic logic [IMG_BITS-1:0] rand_img();
    logic [IMG_BITS-1:0] v;
    for (int w = 0; w < IMG_BITS / DW; w++) v[w*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  function automatic logic [FLT_BITS-1:0] rand_flt();
    logic [FLT_BITS-1:0] v;
    for (int w = 0; w < FLT_BITS / DW; w++) v[w*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  // One start pulse, stray starts at cycles 5 and 40, optional input change while busy.
  task automatic do_run(input string name, input logic [IMG_BITS-1:0] img,
                        input logic [FLT_BITS-1:0] flt, input bit perturb);
    logic [OC_BITS-1:0] exp_oc;
    int done_at [3];
    int done_cnt [3];
    exp_oc = model(img, flt);
    for (int i = 0; i < 3; i++) begin
      done_at[i]  = 0;
      done_cnt[i] = 0;
    end
    @(negedge clk);
    image   = img;
    filters = flt;
    start   = 1'b1;
    for (int n = 1; n <= 170; n++) begin
      @(negedge clk);
      if (n == 1) check({name, " busy_after_start"}, 256'(busy_v), 256'(3'b111));
      for (int i = 0; i < 3; i++) begin
        if (done_v[i]) begin
          done_cnt[i]++;
          if (done_at[i] == 0) done_at[i] = n;
          check($sformatf("%s busy_at_done P%0d", name, pvals[i]), 256'(busy_v[i]), 256'(0));
        end
      end
      if (perturb && n == 3) begin
        image   = rand_img();
        filters = rand_flt();
      end
      start = (n == 5 || n == 40);
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s latency P%0d", name, pvals[i]), 256'(done_at[i]),
            256'(((K + pvals[i] - 1) / pvals[i]) * (LAT + 2) + 1));
      check($sformatf("%s done_pulses P%0d", name, pvals[i]), 256'(done_cnt[i]), 256'(1));
      check($sformatf("%s outputConv P%0d", name, pvals[i]), 256'(oc[i]), 256'(exp_oc));
    end
    $display("run %s: expected outputConv %h", name, exp_oc);
  endtask

  initial begin
    logic [IMG_BITS-1:0] img;
    logic [FLT_BITS-1:0] flt;
    logic [OC_BITS-1:0]  snap;
    reset   = 1'b1;
    start   = 1'b0;
    image   = '0;
    filters = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 256'(busy_v), 256'(0));
    check("reset done", 256'(done_v), 256'(0));
    for (int i = 0; i < 3; i++) check($sformatf("reset outputConv P%0d", pvals[i]), 256'(oc[i]), 256'(0));
    reset = 1'b0;

    // All-ones image (Q8 unity), filter k all (k+1): every output word is 9*(k+1) in Q8.
    for (int w = 0; w < IMG_BITS / DW; w++) img[w*DW +: DW] = 16'h0100;
    for (int k = 0; k < K; k++)
      for (int w = 0; w < FILT_SZ / DW; w++) flt[k*FILT_SZ + w*DW +: DW] = DW'((k + 1) * 256);
    do_run("ones", img, flt, 1'b0);
    for (int k = 0; k < K; k++)
      for (int i = 0; i < 3; i++)
        check($sformatf("ones golden k%0d P%0d", k, pvals[i]),
              256'(oc[i][k*OUT_SZ + (NOW-1)*DW +: DW]), 256'(DW'(9 * (k + 1) * 256)));

    for (int t = 0; t < 3; t++) do_run($sformatf("rand%0d", t), rand_img(), rand_flt(), 1'b1);

    // Filter 0 yields -3 everywhere, filter 1 yields +5.
    flt = rand_flt();
    flt[0 +: 2*FILT_SZ] = '0;
    flt[0*FILT_SZ + (FILT_SZ/DW-1)*DW +: DW] = 16'hFFFD;
    flt[1*FILT_SZ + (FILT_SZ/DW-1)*DW +: DW] = 16'h0005;
    do_run("relu", img, flt, 1'b0);
`ifdef CONV_RELU_EN
    check("relu neg word", 256'(oc[0][(NOW-1)*DW +: DW]), 256'(16'h0000));
`else
    check("relu neg word", 256'(oc[0][(NOW-1)*DW +: DW]), 256'(16'hFFFD));
`endif
    check("relu pos word", 256'(oc[0][OUT_SZ + (NOW-1)*DW +: DW]), 256'(16'h0005));

    // Idle cycles must not disturb captured slices.
    snap = model(img, flt);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("hold P%0d", pvals[i]), 256'(oc[i]), 256'(snap));

    // Reset during pass 1 RUN of the P=2 scheduler.
    @(negedge clk);
    image   = rand_img();
    filters = rand_flt();
    start   = 1'b1;
    for (int n = 1; n <= 62; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("midrun busy P2", 256'(busy_v[0]), 256'(1));
    reset = 1'b1;
    #1;
    check("midreset busy", 256'(busy_v), 256'(0));
    check("midreset done", 256'(done_v), 256'(0));
    for (int i = 0; i < 3; i++) check($sformatf("midreset outputConv P%0d", pvals[i]), 256'(oc[i]), 256'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("postreset done", 256'(done_v), 256'(0));
    end
    do_run("after_reset", rand_img(), rand_flt(), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
